// File: rtl/multi_ff_bank.sv
// ============================================================================
//  Module      : multi_ff_bank
//  Description : Bank of WIDTH flip-flops. A per-cycle mode selects D, T, JK,
//                or SR behaviour per bit, or up/down counting over the bank.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module multi_ff_bank #(
    parameter int               WIDTH = 8,
    parameter logic [WIDTH-1:0] INIT  = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [2:0]       mode,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] qn,
    output logic             sr_err,
    output logic             wrap
);

    localparam logic [2:0] c_MODE_D    = 3'b000;
    localparam logic [2:0] c_MODE_T    = 3'b001;
    localparam logic [2:0] c_MODE_JK   = 3'b010;
    localparam logic [2:0] c_MODE_SR   = 3'b011;
    localparam logic [2:0] c_MODE_UP   = 3'b100;
    localparam logic [2:0] c_MODE_DOWN = 3'b101;

    logic [WIDTH-1:0] state_q, state_d;
    logic             sr_err_q, sr_err_d;
    logic             wrap_q, wrap_d;

    always_comb begin
        state_d  = state_q;
        sr_err_d = 1'b0;
        wrap_d   = 1'b0;
        if (en) begin
            unique case (mode)
                c_MODE_D:    state_d = a;
                c_MODE_T:    state_d = state_q ^ a;
                // JK characteristic equation: Q+ = J & ~Q | ~K & Q
                c_MODE_JK:   state_d = (a & ~state_q) | (~b & state_q);
                // S=R=1 is treated as hold for that bit and flagged
                c_MODE_SR: begin
                    state_d  = (state_q & ~(b & ~a)) | (a & ~b);
                    sr_err_d = |(a & b);
                end
                c_MODE_UP: begin
                    state_d = state_q + WIDTH'(1);
                    wrap_d  = &state_q;
                end
                c_MODE_DOWN: begin
                    state_d = state_q - WIDTH'(1);
                    wrap_d  = ~|state_q;
                end
                default: state_d = state_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= INIT;
            sr_err_q <= 1'b0;
            wrap_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            sr_err_q <= sr_err_d;
            wrap_q   <= wrap_d;
        end
    end

    assign q      = state_q;
    assign qn     = ~state_q;
    assign sr_err = sr_err_q;
    assign wrap   = wrap_q;

endmodule

`default_nettype wire

// File: tb/tb_multi_ff_bank.sv
// ============================================================================
//  Module      : tb_multi_ff_bank
//  Description : Scoreboard bench for multi_ff_bank (WIDTH=4, INIT=0101).
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_multi_ff_bank;

    localparam int         c_W    = 4;
    localparam logic [3:0] c_INIT = 4'b0101;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       en  = 1'b0;
    logic [2:0] mode = 3'b000;
    logic [3:0] a = '0;
    logic [3:0] b = '0;
    logic [3:0] q, qn;
    logic       sr_err, wrap;

    typedef struct packed {
        logic [3:0] q;
        logic       se;
        logic       wr;
    } exp_t;

    exp_t       sb[$];
    int         total = 0;
    int         bad   = 0;
    logic [3:0] m_q;

    multi_ff_bank #(.WIDTH(c_W), .INIT(c_INIT)) dut (
        .clk    (clk),
        .rst    (rst),
        .en     (en),
        .mode   (mode),
        .a      (a),
        .b      (b),
        .q      (q),
        .qn     (qn),
        .sr_err (sr_err),
        .wrap   (wrap)
    );

    always #5 clk = ~clk;

    // Drive one cycle of stimulus and push the behavioural expectation.
    task automatic step(input logic r, input logic e, input logic [2:0] m,
                        input logic [3:0] ia, input logic [3:0] ib);
        exp_t x;
        int   n;
        rst = r; en = e; mode = m; a = ia; b = ib;
        x.se = 1'b0;
        x.wr = 1'b0;
        if (r) begin
            m_q = c_INIT;
        end else if (e) begin
            case (m)
                3'd0: m_q = ia;
                3'd1: m_q = m_q ^ ia;
                3'd2: for (int i = 0; i < 4; i++) begin
                    if (ia[i] && ib[i]) m_q[i] = ~m_q[i];
                    else if (ia[i])     m_q[i] = 1'b1;
                    else if (ib[i])     m_q[i] = 1'b0;
                end
                3'd3: for (int i = 0; i < 4; i++) begin
                    if (ia[i] && ib[i]) x.se = 1'b1;
                    else if (ia[i])     m_q[i] = 1'b1;
                    else if (ib[i])     m_q[i] = 1'b0;
                end
                3'd4: begin
                    n = int'(m_q) + 1;
                    x.wr = (n == 16);
                    m_q = 4'(n % 16);
                end
                3'd5: begin
                    n = int'(m_q) - 1;
                    x.wr = (n < 0);
                    m_q = 4'((n + 16) % 16);
                end
                default: ;
            endcase
        end
        x.q = m_q;
        sb.push_back(x);
        @(negedge clk);
    endtask

    // Monitor: the bank presents a result every cycle after each driven edge.
    initial begin
        exp_t x;
        forever begin
            @(posedge clk);
            #1;
            if (sb.size() > 0) begin
                x = sb.pop_front();
                total++;
                if (q !== x.q || qn !== ~x.q || sr_err !== x.se || wrap !== x.wr) begin
                    bad++;
                    $display("FAIL cycle_check t=%0t: got q=%b qn=%b sr_err=%b wrap=%b, want q=%b qn=%b sr_err=%b wrap=%b",
                             $time, q, qn, sr_err, wrap, x.q, ~x.q, x.se, x.wr);
                end
            end
        end
    end

    initial begin
        m_q = c_INIT;
        @(negedge clk);
        // Reset, then JK sequence from 0101
        step(1, 1, 3'b100, 4'h0, 4'h0);
        step(0, 1, 3'b010, 4'b1100, 4'b1010);
        step(0, 1, 3'b010, 4'b1111, 4'b1111);
        // SR from 0000 with an illegal bit, then quiet
        step(0, 1, 3'b000, 4'b0000, 4'b0000);
        step(0, 1, 3'b011, 4'b0011, 4'b0110);
        step(0, 1, 3'b011, 4'b0000, 4'b0000);
        // Count up across the wrap, then count down across it
        step(0, 1, 3'b000, 4'b1110, 4'b0000);
        repeat (3) step(0, 1, 3'b100, 4'hA, 4'h5);
        step(0, 1, 3'b000, 4'b0000, 4'b0000);
        step(0, 1, 3'b101, 4'h3, 4'hC);
        // Enable low while counting, then reset mid-count at all-ones
        repeat (5) step(0, 0, 3'b100, 4'h0, 4'h0);
        step(0, 1, 3'b000, 4'b1111, 4'b0000);
        step(1, 1, 3'b100, 4'h0, 4'h0);
        step(0, 1, 3'b100, 4'h0, 4'h0);
        // T mode from 0101
        step(1, 0, 3'b000, 4'h0, 4'h0);
        repeat (2) step(0, 1, 3'b001, 4'b1111, 4'h0);
        // Hold modes
        step(0, 1, 3'b110, 4'hF, 4'hF);
        step(0, 1, 3'b111, 4'hF, 4'hF);
        // Randomised traffic, biased toward counting so wraps occur
        for (int k = 0; k < 400; k++) begin
            logic [2:0] m;
            m = 3'($urandom_range(0, 7));
            if ($urandom_range(0, 3) == 0) m = 3'($urandom_range(4, 5));
            step(($urandom_range(0, 24) == 0), ($urandom_range(0, 9) != 0), m,
                 4'($urandom), 4'($urandom));
        end
        step(0, 0, 3'b000, 4'h0, 4'h0);
        repeat (3) @(negedge clk);
        if (sb.size() != 0) begin
            total++;
            bad++;
            $display("FAIL scoreboard_drain: got %0d entries left, want 0", sb.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
